regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line as: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  pipeline writeback request.
- a_dst  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- a_ready  out  1  pipeline request accepted this cycle.
- b_valid  in  1  multicycle-unit writeback request.
- b_dst  in  5  multicycle-unit destination register.
- b_data  in  32  multicycle-unit write data.
- b_ready  out  1  multicycle-unit request accepted this cycle.
- iss_valid  in  1  multicycle op issued; reserve iss_dst.
- iss_dst  in  5  register reserved by the issue.
- srcA, srcB  in  5 each  decode-stage source queries.
- hazardA, hazardB  out  1 each  queried source has a pending multicycle write.
- writeReg  out  1  register-file write enable.
- dstReg  out  5  register-file write address.
- data  out  32  register-file write data.
REQ-002 Reset SHALL be asynchronous and active-low on port reset; there SHALL be one clock, clk.

Function
REQ-003 A request SHALL be accepted in cycle N when valid and ready are both high in N.
REQ-004 At most one request SHALL be accepted per cycle.
REQ-005 Default priority SHALL be fixed: a_ready = 1; b_ready = !a_valid.
REQ-006 writeReg, dstReg and data SHALL be registered: an acceptance in cycle N drives them during cycle N+1 only.
REQ-007 With no acceptance in cycle N, writeReg SHALL be 0 in N+1, and dstReg/data SHALL hold their previous values.
REQ-008 An accepted request with dst = 0 SHALL complete its handshake but SHALL produce writeReg = 0.
REQ-009 The scoreboard SHALL hold busy[31:1], one bit per register r1..r31.
- iss_valid with iss_dst != 0 sets busy[iss_dst] at the clock edge.
- iss_dst = 0 is ignored.
REQ-010 A b write with b_dst != 0 SHALL clear busy[b_dst] at the edge that ends cycle N+1, the same edge at which the register file captures the data.
REQ-011 If a set and a clear of the same bit coincide, the set SHALL win.
REQ-012 hazardA SHALL be combinational: (srcA != 0) && busy[srcA]. hazardB SHALL be the same for srcB.
REQ-013 hazardA/hazardB SHALL also be asserted during cycle N+1 for a b write to the queried register that is in flight.
REQ-014 An a write SHALL NOT alter busy.
REQ-015 Ready SHALL depend only on the valid inputs and internal state. Ready SHALL NOT depend on data or dst.

Reset
REQ-016 While reset = 0, the block SHALL force writeReg = 0, dstReg = 0, data = 0, busy = all zeros and the starvation counter = 0.
REQ-017 Reset SHALL take effect immediately. Requests accepted but not yet written SHALL be discarded.
REQ-018 After reset deasserts, a_ready SHALL be 1 and b_ready SHALL be !a_valid.

Configuration
REQ-019 Macro WB_FAIRNESS_EN SHALL control a 2-bit starvation counter.
REQ-020 With WB_FAIRNESS_EN defined:
- The counter increments each cycle that b_valid = 1 and b is not accepted.
- The counter resets to 0 on any b acceptance or when b_valid = 0.
- When the counter equals 2, b wins: b_ready = 1 and a_ready = 0 for that cycle.
REQ-021 Without WB_FAIRNESS_EN, the counter SHALL be absent and the fixed priority of REQ-005 SHALL always apply.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Pipeline write: a_valid = 1, a_dst = 5, a_data = 0x1234 in cycle N -> writeReg = 1, dstReg = 5, data = 0x1234 in N+1 only.
- Scoreboard: iss_dst = 7, then srcA = 7 -> hazardA = 1 until the b write of r7 is captured; hazardA = 0 the cycle after.
- r0 write: b_dst = 0 accepted -> b_ready = 1, writeReg stays 0; iss_dst = 0 leaves busy unchanged.
- Contention without macro: a_valid and b_valid high for 4 cycles -> a accepted in all 4, b_ready = 0 throughout.
- Contention with WB_FAIRNESS_EN: a_valid and b_valid continuously high -> b accepted on the 3rd cycle, and every 3rd cycle thereafter.
- Reset mid-flight: reset = 0 in N+1 after a b acceptance with b_dst = 9 -> writeReg = 0 immediately and busy[9] = 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback sources (pipeline "a" and
// multicycle unit "b") onto a single register-file write port, and keeps a
// busy scoreboard for registers reserved by multicycle issues.
// Optional build macro WB_FAIRNESS_EN: b wins after losing two cycles in a row.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_dst,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_dst,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_dst,
   input  logic [4:0]  srcA,
   input  logic [4:0]  srcB,
   output logic        hazardA,
   output logic        hazardB,
   output logic        writeReg,
   output logic [4:0]  dstReg,
   output logic [31:0] data
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREG   = 32;

   logic [NREG-1:1]   busy;
   logic [NREG-1:1]   busy_d;
   logic              pend;
   logic [REG_W-1:0]  pend_dst;
   logic [NREG-1:0]   pending;
   logic              starve;
   logic              acc_a;
   logic              acc_b;

`ifdef WB_FAIRNESS_EN
   logic [1:0] wait_cnt;

   // Starvation counter: consecutive cycles b waited without being accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= 2'd0;
      end else if (!b_valid || acc_b) begin
         wait_cnt <= 2'd0;
      end else begin
         wait_cnt <= wait_cnt + 2'd1;
      end
   end

   assign starve = (wait_cnt == 2'd2);
`else
   assign starve = 1'b0;
`endif

   // Grant: a has fixed priority unless b is starving; depends only on valids/state.
   always_comb begin
      a_ready = !starve;
      b_ready = starve || !a_valid;
      acc_a   = a_valid && a_ready;
      acc_b   = b_valid && b_ready;
   end

   // Register-file write port: one cycle after acceptance, r0 writes suppressed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         writeReg <= 1'b0;
         dstReg   <= REG_W'(0);
         data     <= DATA_W'(0);
      end else if (acc_a) begin
         writeReg <= (a_dst != REG_W'(0));
         dstReg   <= a_dst;
         data     <= a_data;
      end else if (acc_b) begin
         writeReg <= (b_dst != REG_W'(0));
         dstReg   <= b_dst;
         data     <= b_data;
      end else begin
         writeReg <= 1'b0;
      end
   end

   // Tracks the b write currently being presented to the register file.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend     <= 1'b0;
         pend_dst <= REG_W'(0);
      end else begin
         pend     <= acc_b && (b_dst != REG_W'(0));
         pend_dst <= b_dst;
      end
   end

   // Scoreboard next state: in-flight b write clears, issue sets; set wins.
   always_comb begin
      busy_d = busy;
      for (int i = 1; i < int'(NREG); i++) begin
         if (pend && (pend_dst == REG_W'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (iss_valid && (iss_dst == REG_W'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         busy <= busy_d;
      end
   end

   // Hazard view: busy bits plus the b write in flight; r0 never hazards.
   always_comb begin
      pending = {busy, 1'b0};
      if (pend) begin
         pending = pending | (NREG'(1) << pend_dst);
      end
      pending[0] = 1'b0;
      hazardA    = pending[srcA];
      hazardB    = pending[srcB];
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_regfile_wb_arbiter;

`ifdef WB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        a_valid;
   logic [4:0]  a_dst;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_dst;
   logic [31:0] b_data;
   logic        b_ready;
   logic        iss_valid;
   logic [4:0]  iss_dst;
   logic [4:0]  srcA;
   logic [4:0]  srcB;
   logic        hazardA;
   logic        hazardB;
   logic        writeReg;
   logic [4:0]  dstReg;
   logic [31:0] data;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_dst     (a_dst),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_dst     (b_dst),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .srcA      (srcA),
      .srcB      (srcB),
      .hazardA   (hazardA),
      .hazardB   (hazardB),
      .writeReg  (writeReg),
      .dstReg    (dstReg),
      .data      (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: set of reserved registers, the b write awaiting
   // capture, expected write-port contents and b's consecutive losses.
   bit          busy_m [32];
   bit          infl;
   bit [4:0]    infl_dst;
   bit          exp_wr;
   bit [4:0]    exp_dst;
   bit [31:0]   exp_data;
   int          losses;
   int          b_acc_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_haz(input bit [4:0] s);
      return (s != 5'd0) && (busy_m[s] || (infl && infl_dst == s));
   endfunction

   task automatic model_clear();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      infl     = 1'b0;
      infl_dst = 5'd0;
      exp_wr   = 1'b0;
      exp_dst  = 5'd0;
      exp_data = 32'd0;
      losses   = 0;
   endtask

   // One clock of stimulus: check combinational outputs, clock, check write port.
   task automatic cycle(input bit av, input bit [4:0] ad, input bit [31:0] adat,
                        input bit bv, input bit [4:0] bd, input bit [31:0] bdat,
                        input bit iv, input bit [4:0] id,
                        input bit [4:0] sa, input bit [4:0] sb);
      bit starve, ea, eb, acc_a, acc_b;
      a_valid = av; a_dst = ad; a_data = adat;
      b_valid = bv; b_dst = bd; b_data = bdat;
      iss_valid = iv; iss_dst = id;
      srcA = sa; srcB = sb;
      #1;
      starve = FAIR && (losses >= 2);
      ea = !starve;
      eb = starve || !av;
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
      check("hazardA", hazardA, exp_haz(sa));
      check("hazardB", hazardB, exp_haz(sb));
      acc_a = av && ea;
      acc_b = bv && eb;
      @(posedge clk);
      if (infl) busy_m[infl_dst] = 1'b0;
      if (iv && id != 5'd0) busy_m[id] = 1'b1;
      infl     = acc_b && (bd != 5'd0);
      infl_dst = bd;
      if (acc_a) begin
         exp_wr = (ad != 5'd0); exp_dst = ad; exp_data = adat;
      end else if (acc_b) begin
         exp_wr = (bd != 5'd0); exp_dst = bd; exp_data = bdat;
      end else begin
         exp_wr = 1'b0;
      end
      losses = (!bv || acc_b) ? 0 : losses + 1;
      if (acc_b) b_acc_cnt++;
      #1;
      check("writeReg", writeReg, exp_wr);
      check("dstReg", dstReg, exp_dst);
      check("data", data, exp_data);
   endtask

   task automatic idle(input bit [4:0] sa);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, sa, 0);
   endtask

   // Assert reset mid-cycle: outputs must clear at once, not at the next edge.
   task automatic do_reset();
      reset = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
      #1;
      model_clear();
      check("rst_writeReg", writeReg, 1'b0);
      check("rst_dstReg", dstReg, 5'd0);
      check("rst_data", data, 32'd0);
      check("rst_hazardA", hazardA, exp_haz(srcA));
      @(posedge clk);
      #1;
      check("rst_hold_writeReg", writeReg, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_a_ready", a_ready, 1'b1);
      check("post_rst_b_ready", b_ready, 1'b1);
      a_valid = 1'b1;
      #1;
      check("post_rst_b_ready_av", b_ready, 1'b0);
      a_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      a_valid = 0; a_dst = 0; a_data = 0;
      b_valid = 0; b_dst = 0; b_data = 0;
      iss_valid = 0; iss_dst = 0; srcA = 0; srcB = 0;
      model_clear();
      b_acc_cnt = 0;
      #2;
      check("init_writeReg", writeReg, 1'b0);
      check("init_dstReg", dstReg, 5'd0);
      check("init_data", data, 32'd0);
      #20;
      reset = 1'b1;

      // Pipeline write lands exactly one cycle later, then drops.
      cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      check("pipe_wr", writeReg, 1'b1);
      check("pipe_dst", dstReg, 5'd5);
      check("pipe_data", data, 32'h1234);
      idle(0);
      check("pipe_wr_drop", writeReg, 1'b0);
      check("pipe_data_hold", data, 32'h1234);

      // Scoreboard: reserve r7, hazard until the b write of r7 is captured.
      cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(7);
      check("sb_hazA_busy", hazardA, 1'b1);
      cycle(0, 0, 0, 1, 7, 32'hBEEF, 0, 0, 7, 0);
      check("sb_hazA_inflight", hazardA, 1'b1);
      idle(7);
      check("sb_hazA_cleared", hazardA, 1'b0);

      // r0: b handshake completes but no write; iss to r0 reserves nothing.
      cycle(0, 0, 0, 1, 0, 32'hDEAD, 1, 0, 0, 0);
      check("r0_no_write", writeReg, 1'b0);
      idle(0);

      // Set beats clear on the same edge.
      cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
      cycle(0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
      idle(3);
      check("set_wins", hazardA, 1'b1);
      cycle(0, 0, 0, 1, 3, 32'h34, 0, 0, 3, 0);
      idle(3);
      idle(3);

      // Contention: a and b both valid for 6 cycles.
      b_acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1, 5'(i + 1), 32'(i), 1, 5'd20, 32'hB0 + 32'(i), 0, 0, 0, 0);
      end
      check("contention_b_accepts", 32'(b_acc_cnt), FAIR ? 32'd2 : 32'd0);
      idle(0);

      // Reset while an accepted b write of r9 is on the write port.
      cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
      check("mid_wr_before_rst", writeReg, 1'b1);
      check("mid_haz_before_rst", hazardA, 1'b1);
      do_reset();
      check("mid_haz9_after_rst", hazardA, 1'b0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
               ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (n == 200) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
